bullet_engine: RTL
==================

Name: bullet_engine

Overview:
Multi-slot bullet manager that owns up to NUM_BULLETS projectiles.
- Accepts fire requests.
- Advances every live bullet once per frame tick, with per-axis wall collision against the maze bitmap.
- Reflects the velocity on each wall hit and retires bullets on bounce-limit or lifetime expiry.
- Sits between tank/fire control and the sprite renderer, and replaces the stand-alone combinational collision check.

Parameters:
NUM_BULLETS, 4, number of bullet slots (1..16)
TILE_WIDTH, 32, tile width in pixels
TILE_HEIGHT, 24, tile height in pixels
MAZE_ROWS, 20, maze rows
MAZE_COLS, 20, maze columns
SPEED, 2, pixels moved per axis per frame (1..7)
MAX_BOUNCES, 3, wall hits allowed; the hit that brings the count to MAX_BOUNCES kills the bullet
LIFETIME, 255, frames a bullet lives (8-bit)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame
fire_req  in  1  request to spawn a bullet
fire_x  in  10  spawn X pixel
fire_y  in  10  spawn Y pixel
fire_dx  in  2  X direction, signed: 01=+1, 11=-1, 00=0
fire_dy  in  2  Y direction, same encoding as fire_dx
fire_ready  out  1  a fire is acceptable this cycle
fire_ack  out  1  pulse: fire accepted
outmaze  in  MAZE_COLS x MAZE_ROWS  unpacked array, 1 = wall
bullet_active  out  NUM_BULLETS  per-slot live flag
bullet_x  out  NUM_BULLETS x 10  per-slot X
bullet_y  out  NUM_BULLETS x 10  per-slot Y
busy  out  1  sweep in progress
frame_overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (Reset_n low at Clk edge):
  - All slots inactive; all coordinates, velocities, bounce and life counters are 0.
  - FSM in IDLE; busy=0, fire_ack=0, frame_overrun=0.
  - Reset mid-sweep aborts the sweep immediately.
- FSM states IDLE, SWEEP, DONE:
  - IDLE -> SWEEP on frame_tick; slot index i is cleared to 0.
  - SWEEP processes slot i in one cycle, then increments i. After slot NUM_BULLETS-1 it goes to DONE.
  - DONE -> IDLE unconditionally.
  - busy=1 in SWEEP and DONE.
- Fire handshake:
  - fire_ready = (state==IDLE) && (any slot inactive).
  - On fire_req && fire_ready, fire_ack pulses in the same cycle and the lowest-index inactive slot loads the request.
  - Loaded values: x, y; velocity = direction*SPEED; bounces=0; life=LIFETIME. The slot is active from the next cycle.
  - fire_dx=fire_dy=0 is still accepted; the bullet stays stationary until its lifetime expires.
  - fire_dx or fire_dy = 10 is treated as 0.
  - fire_req while not ready is ignored; no queueing.
- fire_req and frame_tick in the same IDLE cycle: the fire is accepted and the sweep starts. The new bullet is updated in that sweep.
- frame_tick while busy: the tick is dropped and frame_overrun is set. It clears only on reset.
- Slot update (active slots only; inactive slots pass unchanged):
  - nx = x + vx, ny = y + vy, computed in 11-bit signed.
  - Collision is checked per axis against the old position:
    - colX = nx<0 || nx>=MAZE_COLS*TILE_WIDTH || outmaze[y/TILE_HEIGHT][nx/TILE_WIDTH].
    - colY = ny<0 || ny>=MAZE_ROWS*TILE_HEIGHT || outmaze[ny/TILE_HEIGHT][x/TILE_WIDTH].
  - Per axis: on collision, negate the velocity and keep the coordinate. Otherwise the coordinate takes the new value.
  - Bounce counting: a slot increments bounces by colX + colY (0..2). When bounces reaches >= MAX_BOUNCES the slot goes inactive. A simultaneous X+Y corner hit counts 2.
  - life decrements by 1 each sweep. When it reaches 0 the slot goes inactive in that same update.
  - Deactivation also zeroes the slot's counters. x and y hold their last values.
- Sweep timing: tick at cycle t gives busy from t+1 to t+NUM_BULLETS+1. The last slot's results are visible at t+NUM_BULLETS+1.
- Tile division uses the parameter constants only; no runtime divider.

Decomposition:
- Package bullet_pkg holds:
  - typedef bullet_t {active, x[9:0], y[9:0], vx, vy (4-bit signed), bounces, life[7:0]};
  - the direction encoding constants;
  - the FSM state enum.
- Sub-module bullet_step: combinational next-state for one bullet_t given outmaze. It is instantiated once and muxed by slot index i.

Test Plan:
1. Reset, then fire (100,100,dx=01,dy=00) in an open maze -> fire_ack same cycle, slot 0 active; after 3 ticks x=106, y=100.
2. Wall at column 4 (x 128..159), bullet at x=126 with vx=+2 -> tick 1: x=128 is a wall, so vx becomes -2 and x stays 126, bounces=1; tick 2: x=124.
3. Fire 5 times with NUM_BULLETS=4 -> the first 4 are acked into slots 0..3; the 5th sees fire_ready=0 and no ack.
4. Bullet at corner (1,1) with vx=vy=-2, MAX_BOUNCES=3 -> 2 bounces on tick 1; a further wall hit kills the slot, bullet_active[0]=0.
5. LIFETIME=8 with a stationary bullet -> slot inactive after exactly the 8th tick.
6. Pulse frame_tick on two consecutive cycles -> the second tick is dropped, frame_overrun=1; assert Reset_n low mid-sweep -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared types, direction encoding and FSM states for the bullet engine.
package bullet_pkg;

    localparam logic [1:0] DIR_ZERO = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              active;
        logic [9:0]        x;
        logic [9:0]        y;
        logic signed [3:0] vx;
        logic signed [3:0] vy;
        logic [3:0]        bounces;
        logic [7:0]        life;
    } bullet_t;

    // 2'b10 is not a legal direction and is treated as zero.
    function automatic logic signed [3:0] dir_vel(
        input logic [1:0] dir,
        input int         speed
    );
        case (dir)
            DIR_POS:  dir_vel = 4'(speed);
            DIR_NEG:  dir_vel = -4'(speed);
            DIR_ZERO: dir_vel = '0;
            default:  dir_vel = '0;
        endcase
    endfunction

endpackage

// File: rtl/bullet_step.sv
// One-bullet frame update: move, per-axis wall reflect, bounce/life retire.
module bullet_step
    import bullet_pkg::*;
#(
    parameter int TILE_WIDTH  = 32,
    parameter int TILE_HEIGHT = 24,
    parameter int MAZE_ROWS   = 20,
    parameter int MAZE_COLS   = 20,
    parameter int MAX_BOUNCES = 3
) (
    input  bullet_t cur_i,
    input  logic    outmaze [MAZE_ROWS][MAZE_COLS],
    output bullet_t nxt_o
);

    localparam int X_LIMIT = MAZE_COLS * TILE_WIDTH;
    localparam int Y_LIMIT = MAZE_ROWS * TILE_HEIGHT;
    localparam int RW = (MAZE_ROWS > 1) ? $clog2(MAZE_ROWS) : 1;
    localparam int CW = (MAZE_COLS > 1) ? $clog2(MAZE_COLS) : 1;

    logic signed [11:0] nx;
    logic signed [11:0] ny;
    logic [RW-1:0]      row_old;
    logic [RW-1:0]      row_new;
    logic [CW-1:0]      col_old;
    logic [CW-1:0]      col_new;
    logic               x_in;
    logic               y_in;
    logic               nx_in;
    logic               ny_in;
    logic               col_x;
    logic               col_y;
    logic [4:0]         bounce_sum;
    logic               kill;

    assign nx = $signed({2'b00, cur_i.x}) + $signed({{8{cur_i.vx[3]}}, cur_i.vx});
    assign ny = $signed({2'b00, cur_i.y}) + $signed({{8{cur_i.vy[3]}}, cur_i.vy});

    assign x_in  = {1'b0, cur_i.x} < 11'(X_LIMIT);
    assign y_in  = {1'b0, cur_i.y} < 11'(Y_LIMIT);
    assign nx_in = !nx[11] && (nx[10:0] < 11'(X_LIMIT));
    assign ny_in = !ny[11] && (ny[10:0] < 11'(Y_LIMIT));

    assign row_old = RW'(cur_i.y / 10'(TILE_HEIGHT));
    assign col_old = CW'(cur_i.x / 10'(TILE_WIDTH));
    assign row_new = RW'(ny[10:0] / 11'(TILE_HEIGHT));
    assign col_new = CW'(nx[10:0] / 11'(TILE_WIDTH));

    // A lookup outside the maze counts as a wall.
    always_comb begin
        col_x = 1'b1;
        col_y = 1'b1;
        if (nx_in && y_in) col_x = outmaze[row_old][col_new];
        if (ny_in && x_in) col_y = outmaze[row_new][col_old];
    end

    assign bounce_sum = 5'(cur_i.bounces) + 5'(col_x) + 5'(col_y);
    assign kill = (bounce_sum >= 5'(MAX_BOUNCES)) || (cur_i.life <= 8'd1);

    always_comb begin
        nxt_o = cur_i;
        if (cur_i.active) begin
            if (col_x) nxt_o.vx = -cur_i.vx;
            else       nxt_o.x  = nx[9:0];
            if (col_y) nxt_o.vy = -cur_i.vy;
            else       nxt_o.y  = ny[9:0];
            nxt_o.bounces = bounce_sum[3:0];
            nxt_o.life    = cur_i.life - 8'd1;
            if (kill) begin
                nxt_o.active  = 1'b0;
                nxt_o.bounces = '0;
                nxt_o.life    = '0;
            end
        end
    end

endmodule

// File: rtl/bullet_engine.sv
// Multi-slot bullet manager: fire handshake plus a per-frame slot sweep.
module bullet_engine
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int TILE_WIDTH  = 32,
    parameter int TILE_HEIGHT = 24,
    parameter int MAZE_ROWS   = 20,
    parameter int MAZE_COLS   = 20,
    parameter int SPEED       = 2,
    parameter int MAX_BOUNCES = 3,
    parameter int LIFETIME    = 255
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_tick,
    input  logic                         fire_req,
    input  logic [9:0]                   fire_x,
    input  logic [9:0]                   fire_y,
    input  logic [1:0]                   fire_dx,
    input  logic [1:0]                   fire_dy,
    output logic                         fire_ready,
    output logic                         fire_ack,
    input  logic                         outmaze [MAZE_ROWS][MAZE_COLS],
    output logic [NUM_BULLETS-1:0]       bullet_active,
    output logic [NUM_BULLETS-1:0][9:0]  bullet_x,
    output logic [NUM_BULLETS-1:0][9:0]  bullet_y,
    output logic                         busy,
    output logic                         frame_overrun
);

    localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overrun_q, overrun_d;
    bullet_t          slot_q [NUM_BULLETS];
    bullet_t          slot_d [NUM_BULLETS];
    bullet_t          step_in;
    bullet_t          step_out;
    bullet_t          fire_slot;
    logic             any_free;
    logic [IDX_W-1:0] free_idx;
    logic             sweeping;

    bullet_step #(
        .TILE_WIDTH  (TILE_WIDTH),
        .TILE_HEIGHT (TILE_HEIGHT),
        .MAZE_ROWS   (MAZE_ROWS),
        .MAZE_COLS   (MAZE_COLS),
        .MAX_BOUNCES (MAX_BOUNCES)
    ) u_step (
        .cur_i   (step_in),
        .outmaze (outmaze),
        .nxt_o   (step_out)
    );

    assign step_in  = slot_q[idx_q];
    assign sweeping = (state_q == ST_SWEEP);
    assign busy     = (state_q != ST_IDLE);

    // Lowest-index inactive slot wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int k = NUM_BULLETS - 1; k >= 0; k--) begin
            if (!slot_q[k].active) begin
                any_free = 1'b1;
                free_idx = IDX_W'(k);
            end
        end
    end

    assign fire_ready = Reset_n && (state_q == ST_IDLE) && any_free;
    assign fire_ack   = fire_req && fire_ready;

    always_comb begin
        fire_slot         = '0;
        fire_slot.active  = 1'b1;
        fire_slot.x       = fire_x;
        fire_slot.y       = fire_y;
        fire_slot.vx      = dir_vel(fire_dx, SPEED);
        fire_slot.vy      = dir_vel(fire_dy, SPEED);
        fire_slot.life    = 8'(LIFETIME);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q | (frame_tick & busy);
        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (idx_q == IDX_W'(NUM_BULLETS - 1)) state_d = ST_DONE;
                else                                  idx_d   = idx_q + 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_BULLETS; k++) begin
            slot_d[k] = slot_q[k];
            if (fire_ack && (free_idx == IDX_W'(k))) slot_d[k] = fire_slot;
            if (sweeping && (idx_q == IDX_W'(k)))    slot_d[k] = step_out;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_BULLETS; k++) slot_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < NUM_BULLETS; k++) slot_q[k] <= slot_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_BULLETS; k++) begin
            bullet_active[k] = slot_q[k].active;
            bullet_x[k]      = slot_q[k].x;
            bullet_y[k]      = slot_q[k].y;
        end
    end

    assign frame_overrun = overrun_q;

endmodule
